button_debounce_array: RTL and testbench

BUTTON_DEBOUNCE_ARRAY -- requirements
Module: button_debounce_array

---
 rtl/debounce_pkg.sv | 19 +
 rtl/debounce_channel.sv | 88 ++++++++
 rtl/button_debounce_array.sv | 42 ++++
 tb/tb_button_debounce_array.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and per-channel event bundle for the button debounce array.
package debounce_pkg;

   // Default build-time constants shared by the channel and the array top.
   localparam int unsigned DEF_N_CH          = 4;
   localparam int unsigned DEF_STABLE_CYCLES = 256;
   localparam int unsigned DEF_LONG_CYCLES   = 65536;
   localparam bit          DEF_ACTIVE_LOW    = 1'b1;

   // Everything one debounced channel reports, all active high.
   typedef struct packed {
      logic level;       // debounced pressed state
      logic press;       // one-cycle pulse on level rise
      logic rel;         // one-cycle pulse on level fall
      logic toggle;      // flips on every press pulse
      logic long_press;  // one-cycle pulse once a press has been held long enough
   } btn_evt_t;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchronizer, stability filter, edge pulses,
// press toggle and saturating hold timer for long-press detection.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
   parameter bit          ACTIVE_LOW    = DEF_ACTIVE_LOW
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     btn_raw,
   output btn_evt_t evt
);

   localparam int unsigned SW = $clog2(STABLE_CYCLES);
   localparam int unsigned HW = $clog2(LONG_CYCLES + 1);

   localparam logic          IDLE_RAW    = ACTIVE_LOW ? 1'b1 : 1'b0;
   localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
   localparam logic [HW-1:0] LONG_MAX    = HW'(LONG_CYCLES);
   localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_CYCLES - 1);

   logic [1:0]    sync_q;
   logic          sync_lvl;
   logic [SW-1:0] stab_cnt;
   logic [HW-1:0] hold_cnt;
   logic          level_q;
   logic          press_q;
   logic          rel_q;
   logic          toggle_q;
   logic          long_q;

   // Two-flop synchronizer, reset to the raw value of an unpressed button.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= {2{IDLE_RAW}};
      else        sync_q <= {sync_q[0], btn_raw};
   end

   // Normalise polarity so 1 always means pressed.
   assign sync_lvl = sync_q[1] ^ ACTIVE_LOW;

   // Stability filter: accept a new level only after STABLE_CYCLES disagreeing cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stab_cnt <= '0;
         level_q  <= 1'b0;
         press_q  <= 1'b0;
         rel_q    <= 1'b0;
         toggle_q <= 1'b0;
      end else begin
         // NOTE: pulses default low each cycle so they can only last one clock.
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         if (sync_lvl == level_q) begin
            stab_cnt <= '0;
         end else if (stab_cnt == STABLE_LAST) begin
            stab_cnt <= '0;
            level_q  <= sync_lvl;
            press_q  <= sync_lvl;
            rel_q    <= ~sync_lvl;
            toggle_q <= toggle_q ^ sync_lvl;
         end else begin
            stab_cnt <= stab_cnt + SW'(1);
         end
      end
   end

   // Hold timer: counts while pressed, saturates, fires long_press once on arrival.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= '0;
         long_q   <= 1'b0;
      end else begin
         long_q <= level_q && (hold_cnt == LONG_LAST);
         if (!level_q)                 hold_cnt <= '0;
         else if (hold_cnt != LONG_MAX) hold_cnt <= hold_cnt + HW'(1);
      end
   end

   assign evt.level      = level_q;
   assign evt.press      = press_q;
   assign evt.rel        = rel_q;
   assign evt.toggle     = toggle_q;
   assign evt.long_press = long_q;

endmodule

// File: rtl/button_debounce_array.sv
// Array of independent debounced buttons; one debounce_channel per input pin.
module button_debounce_array
   import debounce_pkg::*;
#(
   parameter int unsigned N_CH          = DEF_N_CH,
   parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
   parameter bit          ACTIVE_LOW    = DEF_ACTIVE_LOW
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] btn_raw,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] press,
   output logic [N_CH-1:0] rel,
   output logic [N_CH-1:0] toggle,
   output logic [N_CH-1:0] long_press
);

   btn_evt_t evt [N_CH];

   // One channel instance per button, outputs fanned back out as bit vectors.
   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      debounce_channel #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .LONG_CYCLES   (LONG_CYCLES),
         .ACTIVE_LOW    (ACTIVE_LOW)
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .btn_raw (btn_raw[g]),
         .evt     (evt[g])
      );

      assign level[g]      = evt[g].level;
      assign press[g]      = evt[g].press;
      assign rel[g]        = evt[g].rel;
      assign toggle[g]     = evt[g].toggle;
      assign long_press[g] = evt[g].long_press;
   end

endmodule

// File: tb/tb_button_debounce_array.sv
// Directed bench for button_debounce_array with short debounce/hold times.
module tb_button_debounce_array;

   localparam int unsigned N_CH          = 4;
   localparam int unsigned STABLE_CYCLES = 4;
   localparam int unsigned LONG_CYCLES   = 10;

   logic            clk;
   logic            rst_n;
   logic [N_CH-1:0] btn_raw;
   logic [N_CH-1:0] level;
   logic [N_CH-1:0] press;
   logic [N_CH-1:0] rel;
   logic [N_CH-1:0] toggle;
   logic [N_CH-1:0] long_press;

   int n_cmp;
   int n_bad;

   button_debounce_array #(
      .N_CH          (N_CH),
      .STABLE_CYCLES (STABLE_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .ACTIVE_LOW    (1'b1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_raw    (btn_raw),
      .level      (level),
      .press      (press),
      .rel        (rel),
      .toggle     (toggle),
      .long_press (long_press)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges, then step 1 ns past the edge to sample/drive.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      rst_n   = 1'b0;
      btn_raw = 4'hF;

      // Reset state
      #1;
      chk("rst_level",  32'(level),      32'h0);
      chk("rst_press",  32'(press),      32'h0);
      chk("rst_rel",    32'(rel),        32'h0);
      chk("rst_toggle", 32'(toggle),     32'h0);
      chk("rst_long",   32'(long_press), 32'h0);
      tick(2);
      rst_n = 1'b1;
      tick(8);
      chk("idle_level", 32'(level), 32'h0);
      chk("idle_press", 32'(press), 32'h0);

      // Channel 0 clean press: level on the 6th edge after driving
      btn_raw[0] = 1'b0;
      tick(5);
      chk("c0_level_early", 32'(level), 32'h0);
      tick(1);
      chk("c0_level",  32'(level),  32'h1);
      chk("c0_press",  32'(press),  32'h1);
      chk("c0_toggle", 32'(toggle), 32'h1);
      tick(1);
      chk("c0_press_1cyc", 32'(press), 32'h0);
      chk("c0_level_hold", 32'(level), 32'h1);

      // Channel 0 short hold then release: rel only, no long_press
      btn_raw[0] = 1'b1;
      tick(5);
      chk("c0_rel_early", 32'(rel),   32'h0);
      chk("c0_lvl_still", 32'(level), 32'h1);
      tick(1);
      chk("c0_rel",       32'(rel),   32'h1);
      chk("c0_lvl_fall",  32'(level), 32'h0);
      chk("c0_no_press",  32'(press), 32'h0);
      tick(1);
      chk("c0_rel_1cyc",  32'(rel),   32'h0);
      tick(6);
      chk("c0_no_long",   32'(long_press), 32'h0);

      // Channel 1 glitch: 3 cycles low is one short of acceptance
      btn_raw[1] = 1'b0;
      tick(3);
      btn_raw[1] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("c1_glitch", 32'({level[1], press[1], rel[1]}), 32'h0);
      end

      // Channel 2 long hold: one long_press 10 cycles after level rose
      btn_raw[2] = 1'b0;
      tick(6);
      chk("c2_press", 32'(press), 32'h4);
      chk("c2_level", 32'(level), 32'h4);
      tick(9);
      chk("c2_long_early", 32'(long_press), 32'h0);
      tick(1);
      chk("c2_long",       32'(long_press), 32'h4);
      tick(1);
      chk("c2_long_1cyc",  32'(long_press), 32'h0);
      tick(9);
      chk("c2_long_once",  32'(long_press), 32'h0);
      chk("c2_level_held", 32'(level),      32'h4);
      btn_raw[2] = 1'b1;
      tick(5);
      chk("c2_rel_early", 32'(rel), 32'h0);
      tick(1);
      chk("c2_rel",       32'(rel),        32'h4);
      chk("c2_rel_long",  32'(long_press), 32'h0);
      chk("c2_rel_press", 32'(press),      32'h0);
      chk("c2_lvl_fall",  32'(level),      32'h0);
      tick(1);
      chk("c2_rel_1cyc",  32'(rel), 32'h0);

      // Channel 3 two press/release sequences: toggle goes 1 then 0
      btn_raw[3] = 1'b0;
      tick(6);
      chk("c3_press1",  32'(press),  32'h8);
      chk("c3_toggle1", 32'(toggle), 32'hD);
      tick(1);
      btn_raw[3] = 1'b1;
      tick(6);
      chk("c3_rel1",    32'(rel),    32'h8);
      chk("c3_toggle1b",32'(toggle), 32'hD);
      tick(2);
      btn_raw[3] = 1'b0;
      tick(6);
      chk("c3_press2",  32'(press),  32'h8);
      chk("c3_toggle2", 32'(toggle), 32'h5);
      tick(1);
      btn_raw[3] = 1'b1;
      tick(6);
      chk("c3_rel2",    32'(rel),    32'h8);
      chk("c3_no_long", 32'(long_press), 32'h0);
      tick(2);

      // All channels pressed on the same edge
      btn_raw = 4'h0;
      tick(5);
      chk("all_press_early", 32'(press), 32'h0);
      tick(1);
      chk("all_press",  32'(press),  32'hF);
      chk("all_level",  32'(level),  32'hF);
      chk("all_toggle", 32'(toggle), 32'hA);
      tick(1);
      chk("all_press_1cyc", 32'(press), 32'h0);
      chk("all_level_hold", 32'(level), 32'hF);

      // Reset mid-hold on channel 0: outputs clear at once, press returns after release
      rst_n   = 1'b0;
      btn_raw = 4'hE;
      #1;
      chk("midrst_level",  32'(level),      32'h0);
      chk("midrst_press",  32'(press),      32'h0);
      chk("midrst_toggle", 32'(toggle),     32'h0);
      chk("midrst_long",   32'(long_press), 32'h0);
      tick(2);
      rst_n = 1'b1;
      tick(5);
      chk("post_rst_early", 32'(press), 32'h0);
      tick(1);
      chk("post_rst_press",  32'(press),  32'h1);
      chk("post_rst_level",  32'(level),  32'h1);
      chk("post_rst_toggle", 32'(toggle), 32'h1);
      tick(1);
      chk("post_rst_1cyc",   32'(press),  32'h0);
      chk("post_rst_no_rel", 32'(rel),    32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
